// File: rtl/meteor_collision.sv
// meteor_collision: player/meteor overlap test, lives counter, post-hit invulnerability and game-over.
// Optional bonus-life counter is built only when METEOR_COLLISION_BONUS_LIFE_EN is defined.
module meteor_collision #(
    parameter int NUM_METEORS   = 6,
    parameter int METEOR_W      = 16,
    parameter int METEOR_H      = 16,
    parameter int PLAYER_W      = 32,
    parameter int PLAYER_H      = 16,
    parameter int PLAYER_Y      = 440,
    parameter int START_LIVES   = 3,
    parameter int MAX_LIVES     = 7,
    parameter int INVULN_CYCLES = 50,
    parameter int BONUS_PASSES  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       game_enable,
    input  logic [9:0]                 player_x,
    input  logic [NUM_METEORS*10-1:0]  meteor_x,
    input  logic [NUM_METEORS*9-1:0]   meteor_y,
    input  logic [NUM_METEORS-1:0]     meteor_active,
    input  logic                       meteor_passed,
    output logic [NUM_METEORS-1:0]     deactivate_meteors,
    output logic                       player_hit,
    output logic [2:0]                 lives,
    output logic                       invulnerable,
    output logic                       game_over
);

    localparam int TIMER_W = $clog2(INVULN_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(INVULN_CYCLES - 1);
    localparam logic [10:0] PW_11  = 11'(PLAYER_W);
    localparam logic [10:0] MW_11  = 11'(METEOR_W);
    localparam logic [10:0] MH_11  = 11'(METEOR_H);
    localparam logic [10:0] PY_TOP = 11'(PLAYER_Y);
    localparam logic [10:0] PY_BOT = 11'(PLAYER_Y + PLAYER_H);
    localparam logic [2:0]  LIVES_RST = 3'(START_LIVES);
    localparam logic [2:0]  LIVES_MAX = 3'(MAX_LIVES);

    typedef enum logic [1:0] {
        S_PLAY   = 2'd0,
        S_INVULN = 2'd1,
        S_OVER   = 2'd2
    } state_t;

    // Eleven-bit operands keep edge sums from wrapping near the screen border.
    function automatic logic box_overlap(input logic [9:0] px, input logic [9:0] mx,
                                         input logic [8:0] my);
        logic [10:0] px_l, mx_l, my_l;
        px_l = {1'b0, px};
        mx_l = {1'b0, mx};
        my_l = {2'b00, my};
        return (mx_l < px_l + PW_11) && (px_l < mx_l + MW_11) &&
               (my_l < PY_BOT) && (PY_TOP < my_l + MH_11);
    endfunction

    logic [NUM_METEORS-1:0] ovl_d, ovl_q;
    state_t                 state_d, state_q;
    logic [TIMER_W-1:0]     timer_d, timer_q;
    logic [2:0]             lives_d, lives_q, lives_up;
    logic [NUM_METEORS-1:0] deact_d, deact_q;
    logic                   hit_d, hit_q;
    logic                   invuln_d, invuln_q;
    logic                   over_d, over_q;
    logic                   award;

    // Stage 1: per-slot overlap mask
    always_comb begin
        ovl_d = '0;
        for (int i = 0; i < NUM_METEORS; i++) begin
            ovl_d[i] = meteor_active[i] &&
                       box_overlap(player_x, meteor_x[i*10 +: 10], meteor_y[i*9 +: 9]);
        end
        if (!game_enable) begin
            ovl_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovl_q <= '0;
        end else begin
            ovl_q <= ovl_d;
        end
    end

`ifdef METEOR_COLLISION_BONUS_LIFE_EN
    logic [5:0] bonus_d, bonus_q;

    always_comb begin
        bonus_d = bonus_q;
        award   = 1'b0;
        if (game_enable && meteor_passed && (state_q != S_OVER)) begin
            if (({1'b0, bonus_q} + 7'd1) == 7'(BONUS_PASSES)) begin
                bonus_d = '0;
                award   = 1'b1;
            end else begin
                bonus_d = bonus_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bonus_q <= '0;
        end else begin
            bonus_q <= bonus_d;
        end
    end
`else
    logic unused_passed;
    assign award         = 1'b0;
    assign unused_passed = meteor_passed | (BONUS_PASSES == 0);
`endif

    // Stage 2: lives / invulnerability FSM with registered outputs
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        lives_d  = lives_q;
        deact_d  = '0;
        hit_d    = 1'b0;
        lives_up = (award && (lives_q < LIVES_MAX)) ? lives_q + 3'd1 : lives_q;
        if (game_enable) begin
            case (state_q)
                S_PLAY: begin
                    if (|ovl_q) begin
                        deact_d = ovl_q;
                        hit_d   = 1'b1;
                        // A bonus landing on the same edge cancels the loss.
                        lives_d = award ? lives_q : lives_q - 3'd1;
                        if (lives_d == 3'd0) begin
                            state_d = S_OVER;
                        end else begin
                            state_d = S_INVULN;
                            timer_d = TIMER_LOAD;
                        end
                    end else begin
                        lives_d = lives_up;
                    end
                end
                S_INVULN: begin
                    deact_d = ovl_q;
                    lives_d = lives_up;
                    if (timer_q == '0) begin
                        state_d = S_PLAY;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                S_OVER: begin
                    lives_d = 3'd0;
                end
                default: begin
                    state_d = S_PLAY;
                end
            endcase
        end
        invuln_d = (state_d == S_INVULN);
        over_d   = (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_PLAY;
            timer_q  <= '0;
            lives_q  <= LIVES_RST;
            deact_q  <= '0;
            hit_q    <= 1'b0;
            invuln_q <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            lives_q  <= lives_d;
            deact_q  <= deact_d;
            hit_q    <= hit_d;
            invuln_q <= invuln_d;
            over_q   <= over_d;
        end
    end

    assign deactivate_meteors = deact_q;
    assign player_hit         = hit_q;
    assign lives              = lives_q;
    assign invulnerable       = invuln_q;
    assign game_over          = over_q;

endmodule

// File: tb/tb_meteor_collision.sv
// Scoreboard bench for meteor_collision: a behavioural model queues expected outputs per driven cycle.
module tb_meteor_collision;

    logic        clk = 1'b0;
    logic        reset;
    logic        game_enable;
    logic [9:0]  player_x;
    logic [59:0] meteor_x;
    logic [53:0] meteor_y;
    logic [5:0]  meteor_active;
    logic        meteor_passed;
    logic [5:0]  deactivate_meteors;
    logic        player_hit;
    logic [2:0]  lives;
    logic        invulnerable;
    logic        game_over;

    always #5 clk = ~clk;

    meteor_collision dut (
        .clk                (clk),
        .reset              (reset),
        .game_enable        (game_enable),
        .player_x           (player_x),
        .meteor_x           (meteor_x),
        .meteor_y           (meteor_y),
        .meteor_active      (meteor_active),
        .meteor_passed      (meteor_passed),
        .deactivate_meteors (deactivate_meteors),
        .player_hit         (player_hit),
        .lives              (lives),
        .invulnerable       (invulnerable),
        .game_over          (game_over)
    );

    typedef struct packed {
        logic [5:0] deact;
        logic       hit;
        logic [2:0] lives;
        logic       inv;
        logic       go;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         inv_cnt  = 0;
    int         m_state  = 0;   // 0 play, 1 invulnerable, 2 over
    int         m_timer  = 0;
    int         m_lives  = 3;
    int         m_bonus  = 0;
    logic [5:0] m_ovl    = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic bit tb_overlap(int px, int mx, int my);
        return (mx < px + 32) && (px < mx + 16) && (my < 456) && (440 < my + 16);
    endfunction

    // Advances the model across the coming edge using the inputs now on the pins.
    task automatic model_step();
        exp_t       e;
        logic [5:0] nxt;
        bit         award;
        e     = '0;
        award = 1'b0;
        if (!reset) begin
            m_state = 0; m_timer = 0; m_lives = 3; m_bonus = 0; m_ovl = '0;
        end else begin
            if (game_enable) begin
`ifdef METEOR_COLLISION_BONUS_LIFE_EN
                if (meteor_passed && m_state != 2) begin
                    m_bonus++;
                    if (m_bonus == 32) begin
                        m_bonus = 0;
                        award   = 1'b1;
                    end
                end
`endif
                if (m_state == 0) begin
                    if (m_ovl != 0) begin
                        e.deact = m_ovl;
                        e.hit   = 1'b1;
                        if (!award) m_lives--;
                        if (m_lives == 0) m_state = 2;
                        else begin m_state = 1; m_timer = 49; end
                    end else if (award && m_lives < 7) begin
                        m_lives++;
                    end
                end else if (m_state == 1) begin
                    e.deact = m_ovl;
                    if (award && m_lives < 7) m_lives++;
                    if (m_timer == 0) m_state = 0;
                    else m_timer--;
                end
            end
            nxt = '0;
            if (game_enable) begin
                for (int i = 0; i < 6; i++)
                    nxt[i] = meteor_active[i] &&
                             tb_overlap(int'(player_x), int'(meteor_x[i*10 +: 10]), int'(meteor_y[i*9 +: 9]));
            end
            m_ovl = nxt;
        end
        e.lives = 3'(m_lives);
        e.inv   = (m_state == 1);
        e.go    = (m_state == 2);
        sb_q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_deact", 32'(deactivate_meteors), 32'(e.deact));
        chk("sb_hit",   32'(player_hit),         32'(e.hit));
        chk("sb_lives", 32'(lives),              32'(e.lives));
        chk("sb_inv",   32'(invulnerable),       32'(e.inv));
        chk("sb_over",  32'(game_over),          32'(e.go));
        if (invulnerable) inv_cnt++;
    endtask

    task automatic set_met(input int i, input int x, input int y);
        meteor_x[i*10 +: 10] = 10'(x);
        meteor_y[i*9 +: 9]   = 9'(y);
        meteor_active[i]     = 1'b1;
    endtask

    task automatic clr_all();
        meteor_active = '0;
    endtask

    task automatic wait_invuln_end(input string tag);
        for (int g = 0; g < 200 && invulnerable; g++) cycle();
        chk(tag, 32'(invulnerable), 32'd0);
    endtask

    task automatic hit_now(input int slot);
        set_met(slot, 110, 430);
        cycle();
        clr_all();
        inv_cnt = 0;
        cycle();
    endtask

    initial begin
        reset = 1'b0; game_enable = 1'b1; player_x = 10'd100;
        meteor_x = '0; meteor_y = '0; meteor_active = '0; meteor_passed = 1'b0;

        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_over",  32'(game_over), 32'd0);
        chk("rst_deact", 32'(deactivate_meteors), 32'd0);

        // Single hit on slot 2, then a harmless overlap during the window
        hit_now(2);
        chk("hit_deact", 32'(deactivate_meteors), 32'b000100);
        chk("hit_pulse", 32'(player_hit), 32'd1);
        chk("hit_lives", 32'(lives), 32'd2);
        chk("hit_inv",   32'(invulnerable), 32'd1);
        repeat (8) cycle();
        set_met(0, 100, 440);
        cycle();
        clr_all();
        cycle();
        chk("inv_deact", 32'(deactivate_meteors), 32'b000001);
        chk("inv_nohit", 32'(player_hit), 32'd0);
        chk("inv_lives", 32'(lives), 32'd2);
        wait_invuln_end("inv_timeout");
        chk("inv_len", 32'(inv_cnt), 32'd50);

        // Touching edges on both sides never overlap
        set_met(5, 132, 440);
        set_met(3, 84, 440);
        repeat (3) cycle();
        clr_all();
        repeat (3) cycle();
        chk("edge_lives", 32'(lives), 32'd2);

        // Overlap while frozen is discarded
        game_enable = 1'b0;
        set_met(3, 100, 440);
        repeat (3) cycle();
        clr_all();
        game_enable = 1'b1;
        repeat (3) cycle();
        chk("frz_lives", 32'(lives), 32'd2);

        // Two meteors in one cycle cost one life
        set_met(1, 90, 440);
        set_met(4, 120, 435);
        cycle();
        clr_all();
        inv_cnt = 0;
        cycle();
        chk("sim_deact", 32'(deactivate_meteors), 32'b010010);
        chk("sim_hit",   32'(player_hit), 32'd1);
        chk("sim_lives", 32'(lives), 32'd1);
        repeat (4) cycle();
        game_enable = 1'b0;
        repeat (20) cycle();
        chk("frz_inv", 32'(invulnerable), 32'd1);
        game_enable = 1'b1;
        wait_invuln_end("sim_timeout");
        chk("frz_len", 32'(inv_cnt), 32'd70);

        // Last life
        hit_now(2);
        chk("go_lives", 32'(lives), 32'd0);
        chk("go_flag",  32'(game_over), 32'd1);
        chk("go_inv",   32'(invulnerable), 32'd0);
        repeat (2) cycle();
        set_met(0, 100, 440);
        repeat (3) cycle();
        clr_all();
        cycle();
        chk("go_deact", 32'(deactivate_meteors), 32'd0);
        chk("go_hit",   32'(player_hit), 32'd0);
        chk("go_stick", 32'(game_over), 32'd1);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("go_rst_lives", 32'(lives), 32'd3);
        chk("go_rst_over",  32'(game_over), 32'd0);

        // Reset in the middle of the window
        hit_now(2);
        repeat (5) cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("mid_rst_inv",   32'(invulnerable), 32'd0);
        chk("mid_rst_lives", 32'(lives), 32'd3);
        repeat (2) cycle();

`ifdef METEOR_COLLISION_BONUS_LIFE_EN
        game_enable = 1'b0;
        meteor_passed = 1'b1;
        repeat (5) cycle();
        game_enable = 1'b1;
        repeat (31) cycle();
        chk("bonus_pre", 32'(lives), 32'd3);
        cycle();
        chk("bonus_post", 32'(lives), 32'd4);
        meteor_passed = 1'b0;
        cycle();
`endif

        // Randomised traffic around the player box
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 6; i++) begin
                meteor_active[i]     = ($urandom_range(0, 24) == 0);
                meteor_x[i*10 +: 10] = 10'($urandom_range(60, 150));
                meteor_y[i*9 +: 9]   = 9'($urandom_range(410, 470));
            end
            player_x      = 10'($urandom_range(90, 110));
            game_enable   = ($urandom_range(0, 9) != 0);
            meteor_passed = ($urandom_range(0, 2) == 0);
            reset         = !(game_over && $urandom_range(0, 3) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/meteor_collision.md
# meteor_collision

Collision stage directly downstream of `meteor_controller`. Each cycle it compares the player's bounding box against every active meteor and pulses `deactivate_meteors` back into the controller for each meteor that overlaps. It also owns the lives counter, the post-hit invulnerability window and the sticky game-over flag that gates `game_enable` at top level.

## Interface

Parameters:
- `NUM_METEORS`, 6: meteor slots; matches the controller.
- `METEOR_W`, 16: meteor box width, pixels.
- `METEOR_H`, 16: meteor box height, pixels.
- `PLAYER_W`, 32: player box width, pixels.
- `PLAYER_H`, 16: player box height, pixels.
- `PLAYER_Y`, 440: fixed player top edge, pixels.
- `START_LIVES`, 3: lives loaded at reset; range 1..`MAX_LIVES`.
- `MAX_LIVES`, 7: saturation ceiling; at most 7.
- `INVULN_CYCLES`, 50: invulnerability length; at least 2.
- `BONUS_PASSES`, 32: meteor passes per extra life; only used with the macro.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `game_enable`  in  1  when low, the block freezes.
- `player_x`  in  10  player box left edge.
- `meteor_x`  in  10 ×`NUM_METEORS`  meteor left edges.
- `meteor_y`  in  9 ×`NUM_METEORS`  meteor top edges.
- `meteor_active`  in  `NUM_METEORS`  slot-valid mask.
- `meteor_passed`  in  1  one-cycle pulse from the controller.
- `deactivate_meteors`  out  `NUM_METEORS`  one-cycle kill mask to the controller.
- `player_hit`  out  1  one-cycle pulse when a life is lost.
- `lives`  out  3  remaining lives.
- `invulnerable`  out  1  high while the FSM is in INVULN.
- `game_over`  out  1  sticky; cleared only by reset.

## Operation

- **Overlap test, stage 1:**
  - Meteor i overlaps when all of the following hold:
    - `meteor_active[i]`
    - `meteor_x < player_x+PLAYER_W`
    - `player_x < meteor_x+METEOR_W`
    - `meteor_y < PLAYER_Y+PLAYER_H`
    - `PLAYER_Y < meteor_y+METEOR_H`
  - All comparisons use 11-bit zero-extended operands, so there is no wrap-around.
  - The result is registered as `ovl[NUM_METEORS-1:0]`.
  - `ovl` is forced to 0 while `game_enable` is low.
- **FSM, stage 2:** states PLAY, INVULN, OVER.
  - **PLAY:** if `|ovl`:
    - `deactivate_meteors <= ovl`, `player_hit <= 1`, and lives are decremented.
    - If the new lives value is 0, go to OVER. Otherwise go to INVULN and load the timer with `INVULN_CYCLES-1`.
  - **INVULN:**
    - Any overlapping meteor is still deactivated (`deactivate_meteors <= ovl`), but with no hit and no decrement.
    - The timer decrements only while `game_enable` is high.
    - When the timer reaches 0, return to PLAY on the next edge.
  - **OVER:**
    - `game_over` = 1.
    - `deactivate_meteors`, `player_hit` and `invulnerable` are all held at 0.
    - Lives are held at 0 until reset.
- **Freeze:** while `game_enable` is low, state, timer, lives and bonus counter hold; all pulses are 0.
- **Repeated kills:** a meteor can be flagged again in the cycle after its kill, because the controller's mask lags. Re-pulsing `deactivate_meteors` is harmless. A second life loss is impossible, because the FSM is already in INVULN or OVER.
- **Simultaneous overlaps:** several meteors overlapping in one cycle cost one life, and all of them are deactivated together.

## Timing

- **Reset values:**
  - `deactivate_meteors` = 0, `player_hit` = 0.
  - `lives` = `START_LIVES`, `invulnerable` = 0, `game_over` = 0.
  - State = PLAY, timer = 0, `ovl` = 0, bonus counter = 0.
- **Latency:** inputs sampled at edge N → `ovl` at N+1 → `deactivate_meteors`, `player_hit` and `lives` updated at edge N+2.
- **INVULN duration:** `invulnerable` is high for exactly `INVULN_CYCLES` enabled cycles, starting the same edge as `player_hit`.
- **Reset mid-operation:** reset asserted in any state, including mid-INVULN or OVER, returns all reset values on the next edge.

## Configuration

- **`METEOR_COLLISION_BONUS_LIFE_EN` defined:**
  - A 6-bit counter increments on each `meteor_passed` while `game_enable` is high and the state is not OVER.
  - When the counter reaches `BONUS_PASSES` it clears, and lives increment, saturating at `MAX_LIVES`.
  - Award and hit in the same cycle leave lives unchanged and still enter INVULN.
- **Macro undefined:** `meteor_passed` is ignored, no counter is synthesised, and lives only ever decrease.

## Test plan

1. **Reset state:** reset low 3 cycles, then high → `lives`=3, `game_over`=0, `deactivate_meteors`=0.
2. **Single hit:** `player_x`=100, meteor 2 active at (110,430) → 2 cycles later `deactivate_meteors`=6'b000100 and a `player_hit` pulse, `lives`=2, `invulnerable` high for 50 cycles.
3. **Invulnerable overlap:** meteor 0 overlapping at cycle 10 of INVULN → `deactivate_meteors`=6'b000001, no `player_hit`, `lives` stays 2.
4. **Edges and simultaneous hits:**
   - Meteor at x=132 (touching the right edge) → no hit.
   - Meteors 1 and 4 overlapping in the same cycle → mask 6'b010010, `lives` decrements by exactly 1.
5. **Game over:** three hits spaced beyond the INVULN window → `lives`=0, `game_over`=1. A later overlap produces no pulses. Reset clears everything.
6. **Bonus life (macro defined):** 32 `meteor_passed` pulses at `lives`=3 → `lives`=4. With `game_enable` low, pulses are ignored and the timer holds.
